// File: rtl/pe_stream_pkt_tracker_if.sv
// Bundle of the upstream beat, downstream beat and descriptor channels of the packet tracker.
// The master side drives beats and ready signals; the slave side is the tracker itself.
interface pe_stream_pkt_tracker_if #(
    parameter int TUSER_WIDTH = 128,
    parameter int TDATA_WIDTH = 256,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int LEN_WIDTH   = 16
);
    logic                   in_reg_tvalid;
    logic                   in_reg_tstart;
    logic                   in_reg_tlast;
    logic [TUSER_WIDTH-1:0] in_reg_tuser;
    logic [TDATA_WIDTH-1:0] in_reg_tdata;
    logic [TKEEP_WIDTH-1:0] in_reg_tkeep;
    logic                   in_reg_tready;

    logic                   out_tvalid;
    logic                   out_tstart;
    logic                   out_tlast;
    logic [TDATA_WIDTH-1:0] out_tdata;
    logic [TKEEP_WIDTH-1:0] out_tkeep;
    logic                   out_tready;

    logic                   desc_valid;
    logic [TUSER_WIDTH-1:0] desc_tuser;
    logic [LEN_WIDTH-1:0]   desc_byte_cnt;
    logic [LEN_WIDTH-1:0]   desc_beat_cnt;
    logic                   desc_err;
    logic                   desc_ready;

    logic [15:0]            drop_cnt;

    modport master (
        output in_reg_tvalid, in_reg_tstart, in_reg_tlast, in_reg_tuser, in_reg_tdata, in_reg_tkeep,
        output out_tready, desc_ready,
        input  in_reg_tready,
        input  out_tvalid, out_tstart, out_tlast, out_tdata, out_tkeep,
        input  desc_valid, desc_tuser, desc_byte_cnt, desc_beat_cnt, desc_err,
        input  drop_cnt
    );

    modport slave (
        input  in_reg_tvalid, in_reg_tstart, in_reg_tlast, in_reg_tuser, in_reg_tdata, in_reg_tkeep,
        input  out_tready, desc_ready,
        output in_reg_tready,
        output out_tvalid, out_tstart, out_tlast, out_tdata, out_tkeep,
        output desc_valid, desc_tuser, desc_byte_cnt, desc_beat_cnt, desc_err,
        output drop_cnt
    );
endinterface

// File: rtl/pe_stream_pkt_tracker.sv
// Zero-latency stream pass-through that delimits packets, counts beats/bytes per packet,
// emits a one-deep descriptor per packet and discards beats arriving outside a packet.
module pe_stream_pkt_tracker #(
    parameter int TUSER_WIDTH = 128,
    parameter int TDATA_WIDTH = 256,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int LEN_WIDTH   = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    pe_stream_pkt_tracker_if.slave bus
);
    typedef enum logic {IDLE, PKT} state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

    state_t                 state, state_nxt;
    logic [TUSER_WIDTH-1:0] meta, meta_nxt;
    logic [LEN_WIDTH-1:0]   beat_cnt, beat_nxt;
    logic [LEN_WIDTH-1:0]   byte_cnt, byte_nxt;
    logic                   sat, sat_nxt;

    logic [TDATA_WIDTH-1:0] data;
    logic [LEN_WIDTH-1:0]   keep_bytes;
    logic [LEN_WIDTH:0]     beat_sum, byte_sum;
    logic [LEN_WIDTH-1:0]   beat_inc, byte_inc;
    logic                   in_pkt, desc_stall, orphan, restart_close, accept;

    logic                   desc_load, load_err;
    logic [TUSER_WIDTH-1:0] load_tuser;
    logic [LEN_WIDTH-1:0]   load_beat, load_byte;

    function automatic logic [LEN_WIDTH-1:0] popcount(input logic [TKEEP_WIDTH-1:0] keep);
        logic [LEN_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < TKEEP_WIDTH; i++) n = n + LEN_WIDTH'(keep[i]);
        return n;
    endfunction

    assign in_pkt     = (state == PKT);
    assign desc_stall = bus.desc_valid & ~bus.desc_ready;
    // Orphans only exist out of reset so that ready mirrors out_tready while rst_n is low.
    assign orphan     = rst_n & ~in_pkt & ~bus.in_reg_tstart;
    // A start+last beat on an open packet would need two descriptors at once: hold it one
    // cycle while the abandoned packet is closed, then accept it as a single-beat packet.
    assign restart_close = in_pkt & bus.in_reg_tstart & bus.in_reg_tlast;

    assign bus.in_reg_tready = orphan | (bus.out_tready & ~desc_stall & ~restart_close);
    assign bus.out_tvalid    = bus.in_reg_tvalid & ~orphan & ~desc_stall & ~restart_close;
    assign data              = bus.in_reg_tdata;
    assign bus.out_tdata     = data;
    assign bus.out_tkeep     = bus.in_reg_tkeep;
    assign bus.out_tstart    = bus.in_reg_tstart;
    assign bus.out_tlast     = bus.in_reg_tlast;
    assign accept            = bus.in_reg_tvalid & bus.in_reg_tready;

    assign keep_bytes = popcount(bus.in_reg_tkeep);
    assign beat_sum   = {1'b0, beat_cnt} + (LEN_WIDTH + 1)'(1);
    assign byte_sum   = {1'b0, byte_cnt} + {1'b0, keep_bytes};
    assign beat_inc   = beat_sum[LEN_WIDTH] ? LEN_MAX : beat_sum[LEN_WIDTH-1:0];
    assign byte_inc   = byte_sum[LEN_WIDTH] ? LEN_MAX : byte_sum[LEN_WIDTH-1:0];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        meta_nxt   = meta;
        beat_nxt   = beat_cnt;
        byte_nxt   = byte_cnt;
        sat_nxt    = sat;
        desc_load  = 1'b0;
        load_tuser = meta;
        load_beat  = beat_cnt;
        load_byte  = byte_cnt;
        load_err   = 1'b1;

        if (restart_close && bus.in_reg_tvalid && !desc_stall) begin
            desc_load = 1'b1;
            state_nxt = IDLE;
        end else if (accept && !orphan) begin
            if (bus.in_reg_tstart) begin
                desc_load = in_pkt;
                meta_nxt  = bus.in_reg_tuser;
                beat_nxt  = LEN_WIDTH'(1);
                byte_nxt  = keep_bytes;
                sat_nxt   = 1'b0;
                state_nxt = PKT;
            end else begin
                beat_nxt = beat_inc;
                byte_nxt = byte_inc;
                sat_nxt  = sat | beat_sum[LEN_WIDTH] | byte_sum[LEN_WIDTH];
            end
            if (bus.in_reg_tlast) begin
                desc_load  = 1'b1;
                load_tuser = meta_nxt;
                load_beat  = beat_nxt;
                load_byte  = byte_nxt;
                load_err   = sat_nxt;
                state_nxt  = IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            meta     <= '0;
            beat_cnt <= '0;
            byte_cnt <= '0;
            sat      <= 1'b0;
        end else begin
            state    <= state_nxt;
            meta     <= meta_nxt;
            beat_cnt <= beat_nxt;
            byte_cnt <= byte_nxt;
            sat      <= sat_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.desc_valid    <= 1'b0;
            bus.desc_tuser    <= '0;
            bus.desc_beat_cnt <= '0;
            bus.desc_byte_cnt <= '0;
            bus.desc_err      <= 1'b0;
        end else if (desc_load) begin
            bus.desc_valid    <= 1'b1;
            bus.desc_tuser    <= load_tuser;
            bus.desc_beat_cnt <= load_beat;
            bus.desc_byte_cnt <= load_byte;
            bus.desc_err      <= load_err;
        end else if (bus.desc_ready) begin
            bus.desc_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.drop_cnt <= '0;
        end else if (accept && orphan && bus.drop_cnt != 16'hFFFF) begin
            bus.drop_cnt <= bus.drop_cnt + 16'd1;
        end
    end
endmodule
